// File: rtl/token_requester_if.sv
// Job intake and token-ring req/ack signals for one token_requester.
// The master side is the requester itself; the slave side is the job source plus controller.
`timescale 1ns/1ps
interface token_requester_if #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
);
  logic                     job_valid;
  logic [LEN_W-1:0]         job_len;
  logic                     job_ready;
  logic                     ack;
  logic                     req;
  logic                     busy;
  logic                     done;
  logic [$clog2(DEPTH):0]   pending;
  logic                     err;

  modport master (
    input  job_valid, job_len, ack,
    output job_ready, req, busy, done, pending, err
  );

  modport slave (
    output job_valid, job_len, ack,
    input  job_ready, req, busy, done, pending, err
  );
endinterface

// File: rtl/token_requester.sv
// Client-side token-ring initiator: queues hold-length jobs and runs one
// req/ack handshake per job, holding the token for max(len,1) acked cycles.
`timescale 1ns/1ps
module token_requester #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  token_requester_if.master  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [LEN_W-1:0]   head;
  logic [LEN_W-1:0]   hold_q, hold_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               job_ready;
  logic               push, pop;

  // No bypass when full: a pop on the same edge does not free a slot for the push.
  assign job_ready = (count < FULL_CNT);
  assign push      = bus.job_valid && job_ready;
  assign pop       = (state_q == IDLE) && (count != '0) && !bus.ack;
  assign head      = mem[rd_ptr];

  assign bus.job_ready = job_ready;
  assign bus.req       = req_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.pending   = count;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.job_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = REQ;
          req_d   = 1'b1;
          wait_d  = '0;
          hold_d  = (head == '0) ? LEN_W'(1) : head;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (bus.ack) begin
          state_d = HOLD;
          wait_d  = '0;
        end else begin
          if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
          end
          if (wait_q >= WAIT_LAST) begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // The controller dropping ack mid-hold is a protocol error; give the token back.
        if (!bus.ack) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = RELEASE;
        end else if (hold_q == LEN_W'(1)) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RELEASE: begin
        req_d = 1'b0;
        if (!bus.ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_token_requester.sv
// Self-checking bench for token_requester: table-driven jobs against an auto-acking
// controller, a hold-width scoreboard, and hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_token_requester;
  localparam int DEPTH   = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [LEN_W-1:0] len;
    int               ack_delay;
    int               exp_hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  token_requester_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  token_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks   = 0;
  int   n_errors   = 0;
  int   exp_q[$];
  int   done_seen  = 0;
  int   jobs_exp   = 0;
  logic auto_ack   = 1'b0;
  logic auto_val   = 1'b0;
  logic manual_ack = 1'b0;
  int   ack_delay  = 0;
  int   age        = 0;
  logic req_at_neg = 1'b0;
  logic prev_req   = 1'b0;
  logic prev_done  = 1'b0;
  int   hold_edges = 0;
  vec_t vecs[5];

  assign bus.ack = auto_ack ? auto_val : manual_ack;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [LEN_W-1:0] len, input int exp_hold);
    logic accepted;
    int   n;
    exp_q.push_back(exp_hold);
    jobs_exp++;
    bus.job_valid = 1'b1;
    bus.job_len   = len;
    n = 0;
    do begin
      accepted = bus.job_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!accepted && n < 100);
    bus.job_valid = 1'b0;
    checkOutput("job_accepted", int'(accepted), 1);
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("done_count", done_seen, target);
  endtask

  task automatic resetDut();
    rst_n      = 1'b0;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n;
    int   snap;
    logic saw;

    vecs[0] = '{len: 4'd3,  ack_delay: 2, exp_hold: 3};
    vecs[1] = '{len: 4'd0,  ack_delay: 0, exp_hold: 1};
    vecs[2] = '{len: 4'd1,  ack_delay: 1, exp_hold: 1};
    vecs[3] = '{len: 4'd8,  ack_delay: 3, exp_hold: 8};
    vecs[4] = '{len: 4'd15, ack_delay: 0, exp_hold: 15};

    bus.job_valid = 1'b0;
    bus.job_len   = '0;

    fork
      // Monitor: hold-width scoreboard and done pulse counting, sampled mid-cycle.
      forever begin
        @(negedge clk);
        req_at_neg = bus.req;
        if (!rst_n) begin
          prev_req   = 1'b0;
          prev_done  = 1'b0;
          hold_edges = 0;
        end else begin
          if (bus.done) begin
            done_seen++;
            checkOutput("done_single_cycle", int'(prev_done), 0);
          end
          prev_done = bus.done;
          if (bus.req && bus.ack) hold_edges++;
          if (prev_req && !bus.req) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("[TB] FAIL hold_unexpected: got req pulse with %0d acked edges, expected none", hold_edges);
            end else begin
              checkOutput("hold_width", hold_edges - 1, exp_q.pop_front());
            end
            hold_edges = 0;
          end
          prev_req = bus.req;
        end
      end
      // Controller model: raise ack ack_delay cycles after req, drop it one edge after seeing req low.
      forever begin
        @(posedge clk);
        #1;
        if (!auto_ack) begin
          auto_val = 1'b0;
          age      = 0;
        end else if (auto_val && !req_at_neg) begin
          auto_val = 1'b0;
        end else if (!auto_val && bus.req) begin
          if (age >= ack_delay) begin
            auto_val = 1'b1;
            age      = 0;
          end else begin
            age++;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req", bus.req, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_pending", bus.pending, 0);
    checkOutput("rst_job_ready", bus.job_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven jobs against the auto-acking controller
    for (int i = 0; i < 5; i++) begin
      ack_delay = vecs[i].ack_delay;
      auto_ack  = 1'b1;
      applyStimulus(vecs[i].len, vecs[i].exp_hold);
      waitDone(jobs_exp);
      checkOutput("vec_pending", bus.pending, 0);
      checkOutput("vec_busy", bus.busy, 0);
      checkOutput("vec_req", bus.req, 0);
      checkOutput("vec_err", bus.err, 0);
    end

    // Request latency: pending visible one cycle, then pop and req
    auto_ack = 1'b0;
    bus.job_valid = 1'b1;
    bus.job_len   = 4'd2;
    exp_q.push_back(2);
    jobs_exp++;
    @(posedge clk);
    #1;
    bus.job_valid = 1'b0;
    checkOutput("lat_pending", bus.pending, 1);
    checkOutput("lat_req_early", bus.req, 0);
    checkOutput("lat_busy_early", bus.busy, 0);
    @(posedge clk);
    #1;
    checkOutput("lat_req", bus.req, 1);
    checkOutput("lat_pending_popped", bus.pending, 0);
    checkOutput("lat_busy", bus.busy, 1);
    ack_delay = 0;
    auto_ack  = 1'b1;
    waitDone(jobs_exp);

    // FIFO fill with ack held low, then overflow retry and in-order service
    auto_ack = 1'b0;
    begin
      int exp_pend[5] = '{1, 1, 2, 3, 4};
      int exp_rdy[5]  = '{1, 1, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
        bus.job_valid = 1'b1;
        bus.job_len   = LEN_W'(i + 1);
        exp_q.push_back(i + 1);
        jobs_exp++;
        @(posedge clk);
        #1;
        checkOutput("fifo_pending", bus.pending, exp_pend[i]);
        checkOutput("fifo_ready", bus.job_ready, exp_rdy[i]);
      end
    end
    bus.job_len = 4'd6;
    exp_q.push_back(6);
    jobs_exp++;
    @(posedge clk);
    #1;
    checkOutput("fifo_full_pending", bus.pending, 4);
    checkOutput("fifo_full_ready", bus.job_ready, 0);
    ack_delay = 0;
    auto_ack  = 1'b1;
    begin
      logic accepted;
      n = 0;
      do begin
        accepted = bus.job_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!accepted && n < 100);
      bus.job_valid = 1'b0;
      checkOutput("fifo_retry_accepted", int'(accepted), 1);
    end
    waitDone(jobs_exp);
    checkOutput("fifo_drained", bus.pending, 0);
    checkOutput("fifo_err", bus.err, 0);

    // Premature ack drop during a len=4 hold
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    applyStimulus(4'd4, 1);
    @(posedge clk);
    #1;
    checkOutput("pre_req", bus.req, 1);
    manual_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    manual_ack = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_req_fell", bus.req, 0);
    checkOutput("pre_err", bus.err, 1);
    @(posedge clk);
    #1;
    checkOutput("pre_done", bus.done, 1);
    waitDone(jobs_exp);
    ack_delay = 1;
    auto_ack  = 1'b1;
    applyStimulus(4'd2, 2);
    waitDone(jobs_exp);
    checkOutput("pre_err_sticky", bus.err, 1);
    checkOutput("pre_next_pending", bus.pending, 0);

    resetDut();
    checkOutput("reset_clears_err", bus.err, 0);

    // Timeout: no ack for TIMEOUT REQ edges
    applyStimulus(4'd2, 2);
    @(posedge clk);
    #1;
    checkOutput("to_req", bus.req, 1);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checkOutput("to_err_before", bus.err, 0);
    @(posedge clk);
    #1;
    checkOutput("to_err", bus.err, 1);
    checkOutput("to_req_held", bus.req, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("to_req_still", bus.req, 1);
    ack_delay = 0;
    auto_ack  = 1'b1;
    waitDone(jobs_exp);
    checkOutput("to_err_sticky", bus.err, 1);

    // Asynchronous reset in HOLD with two jobs queued
    ack_delay = 0;
    auto_ack  = 1'b1;
    applyStimulus(4'd15, 15);
    applyStimulus(4'd1, 1);
    applyStimulus(4'd2, 2);
    n = 0;
    while (!(bus.req && bus.ack) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("mid_hold_reached", int'(bus.req && bus.ack), 1);
    @(posedge clk);
    #1;
    checkOutput("mid_pending", bus.pending, 2);
    #2;
    rst_n      = 1'b0;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    exp_q.delete();
    jobs_exp = done_seen;
    snap     = done_seen;
    #1;
    checkOutput("async_req", bus.req, 0);
    checkOutput("async_pending", bus.pending, 0);
    checkOutput("async_busy", bus.busy, 0);
    checkOutput("async_err", bus.err, 0);
    checkOutput("async_done", bus.done, 0);
    checkOutput("async_job_ready", bus.job_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.req || bus.busy) saw = 1'b1;
    end
    checkOutput("post_reset_idle", int'(saw), 0);
    checkOutput("post_reset_no_done", done_seen, snap);
    checkOutput("post_reset_pending", bus.pending, 0);

    // Fresh job after reset
    ack_delay = 1;
    auto_ack  = 1'b1;
    applyStimulus(4'd3, 3);
    waitDone(jobs_exp);
    checkOutput("final_err", bus.err, 0);
    checkOutput("final_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
